// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Servo PWM frame generator. Each frame is PERIOD_CYCLES clocks long and
//   starts with a high pulse of MIN_PULSE_CYCLES + a*STEP_CYCLES clocks, where
//   a is the commanded angle clamped to ANGLE_MAX. The angle is sampled only
//   at frame start, so mid-frame changes never produce runt or stretched
//   pulses. Frames run back-to-back while enable is high. A frame that has
//   started always completes, even if enable drops partway through.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   enable       level, 1 = generate frames
//   angle[7:0]   commanded angle in degrees
//   pwm          servo drive pulse (registered)
//   done_period  one-cycle strobe on the last clock of each frame
//   active       1 while a frame is in progress
//   cur_angle    angle latched for the current frame, after clamping
//   clamp_flag   one-cycle pulse in frame cycle 0 when the latched angle was clamped
module servo_pwm_gen #(
    parameter int unsigned PERIOD_CYCLES    = 2000000,
    parameter int unsigned MIN_PULSE_CYCLES = 100000,
    parameter int unsigned STEP_CYCLES      = 555,
    parameter int unsigned ANGLE_MAX        = 180
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       enable,
    input  logic [7:0] angle,
    output logic       pwm,
    output logic       done_period,
    output logic       active,
    output logic [7:0] cur_angle,
    output logic       clamp_flag
);

    localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST    = CNT_W'(PERIOD_CYCLES - 2);
    localparam logic [CNT_W-1:0] MIN_PULSE_C = CNT_W'(MIN_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(STEP_CYCLES);
    localparam logic [7:0]       ANGLE_MAX_B = 8'(ANGLE_MAX);

    // The longest possible pulse must leave at least one low clock in the frame,
    // and the angle limit has to fit the 8-bit command.
    generate
        if ((64'(MIN_PULSE_CYCLES) + 64'(ANGLE_MAX) * 64'(STEP_CYCLES)
                >= 64'(PERIOD_CYCLES)) || (MIN_PULSE_CYCLES < 1)
                || (ANGLE_MAX > 255)) begin : g_bad_params
            $error("servo_pwm_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pulse_len;

    logic             angle_over;
    logic [7:0]       angle_clamped;
    logic [CNT_W-1:0] pulse_calc;
    logic             start_frame;

    // Pulse length of the next frame. With the parameter check above, every
    // intermediate value (clamped angle, product, sum) is below PERIOD_CYCLES,
    // so CNT_W bits hold the exact result.
    always_comb begin
        angle_over    = (angle > ANGLE_MAX_B);
        angle_clamped = angle_over ? ANGLE_MAX_B : angle;
        pulse_calc    = MIN_PULSE_C + CNT_W'(angle_clamped) * STEP_C;
    end

    // A new frame starts from IDLE, or straight after the last clock of a
    // frame, so that frames follow each other with no gap. The pulse always
    // ends before the last clock, so the frame end is only ever seen in LOW.
    always_comb begin
        start_frame = enable && ((state == IDLE) ||
                                 ((state == LOW) && (cnt == LAST_CNT)));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            pulse_len   <= '0;
            pwm         <= 1'b0;
            done_period <= 1'b0;
            active      <= 1'b0;
            cur_angle   <= '0;
            clamp_flag  <= 1'b0;
        end else begin
            done_period <= 1'b0;
            clamp_flag  <= 1'b0;

            if (start_frame) begin
                state      <= HIGH;
                cnt        <= '0;
                pulse_len  <= pulse_calc;
                cur_angle  <= angle_clamped;
                clamp_flag <= angle_over;
                pwm        <= 1'b1;
                active     <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        pwm    <= 1'b0;
                        active <= 1'b0;
                    end

                    HIGH: begin
                        cnt <= cnt + 1'b1;
                        // pwm is registered: dropping it at the edge that
                        // ends cycle pulse_len-1 gives exactly pulse_len
                        // high clocks.
                        if (cnt == pulse_len - 1'b1) begin
                            state <= LOW;
                            pwm   <= 1'b0;
                        end
                        // Reachable only when the pulse fills all but the
                        // last clock of the frame.
                        if (cnt == PRE_LAST) begin
                            done_period <= 1'b1;
                        end
                    end

                    LOW: begin
                        if (cnt == LAST_CNT) begin
                            // Frame over and enable low: stop here.
                            state  <= IDLE;
                            cnt    <= '0;
                            pwm    <= 1'b0;
                            active <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                            // Registered strobe, set one clock early so it
                            // is high during the last clock of the frame.
                            if (cnt == PRE_LAST) begin
                                done_period <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        pwm    <= 1'b0;
                        active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
